aes_iter_encrypt: RTL and testbench



---
 rtl/aes_iter_encrypt_if.sv | 21 ++
 rtl/aes_iter_encrypt.sv | 207 ++++++++++++++++++++
 tb/tb_aes_iter_encrypt.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_iter_encrypt_if.sv
// Stream handshake bundle for the iterative AES-128 core: block-in and
// ciphertext-out valid/ready channels.
interface aes_iter_encrypt_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext
   );
endinterface

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock, on-the-fly key
// expansion, valid/ready handshakes on both sides.
module aes_iter_encrypt #(
   parameter int unsigned UNROLL = 1
) (
   input logic              clk,
   input logic              rst,
   aes_iter_encrypt_if.slave bus
);

   generate
      if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
         $error("aes_iter_encrypt: UNROLL must be 1, 2, 5 or 10");
      end
   endgenerate

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Byte b of the table lives at bits [(255-b)*8 +: 8].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
      w0  = k[127:96];
      w1  = k[95:64];
      w2  = k[63:32];
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] o;
      for (int unsigned i = 0; i < 16; i++) begin
         a[i] = sbox(s[127 - 8*i -: 8]);
      end
      // Byte index is row + 4*col; row r rotates left by r columns.
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            t[r + 4*c] = a[r + 4*((c + r) % 4)];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         if (last) begin
            m[4*c]     = t[4*c];
            m[4*c + 1] = t[4*c + 1];
            m[4*c + 2] = t[4*c + 2];
            m[4*c + 3] = t[4*c + 3];
         end else begin
            m[4*c]     = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            m[4*c + 1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c + 2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
            m[4*c + 3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
         end
      end
      for (int unsigned i = 0; i < 16; i++) begin
         o[127 - 8*i -: 8] = m[i];
      end
      return o ^ rk;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] rkey_q, rkey_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] ct_q, ct_d;
   logic         ov_q, ov_d;

   logic         in_ready_c;
   logic         accept_c;
   logic         last_c;
   logic [3:0]   r_c;
   logic [127:0] s_c, k_c;

   assign in_ready_c     = !rst && ((state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready));
   assign accept_c       = bus.in_valid && in_ready_c;
   assign last_c         = ({1'b0, rnd_q} + 5'(UNROLL)) == 5'd11;
   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = ov_q;
   assign bus.ciphertext = ct_q;

   always_comb begin
      s_c = blk_q;
      k_c = rkey_q;
      r_c = rnd_q;
      for (int unsigned u = 0; u < UNROLL; u++) begin
         r_c = rnd_q + 4'(u);
         k_c = key_step(k_c, rcon(r_c));
         s_c = aes_round(s_c, k_c, r_c == 4'd10);
      end
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      rkey_d  = rkey_q;
      rnd_d   = rnd_q;
      ct_d    = ct_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               blk_d   = bus.plaintext ^ bus.key;
               rkey_d  = bus.key;
               rnd_d   = 4'd1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            blk_d  = s_c;
            rkey_d = k_c;
            rnd_d  = rnd_q + 4'(UNROLL);
            if (last_c) begin
               ct_d    = s_c;
               ov_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Output-accept cycle doubles as the next input-accept cycle.
            if (bus.out_ready) begin
               ov_d = 1'b0;
               if (accept_c) begin
                  blk_d   = bus.plaintext ^ bus.key;
                  rkey_d  = bus.key;
                  rnd_d   = 4'd1;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         blk_q   <= '0;
         rkey_q  <= '0;
         rnd_q   <= '0;
         ct_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         rkey_q  <= rkey_d;
         rnd_q   <= rnd_d;
         ct_q    <= ct_d;
         ov_q    <= ov_d;
      end
   end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Self-checking bench for aes_iter_encrypt: FIPS-197 vectors, handshake corner
// cases and random traffic against a byte-level AES reference model.
module tb_aes_iter_encrypt;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk = 1'b0;
   logic rst, rst_sw;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic rand_or = 1'b0;
   logic sweep_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_iter_encrypt_if bus1 ();
   aes_iter_encrypt_if b2 ();
   aes_iter_encrypt_if b5 ();
   aes_iter_encrypt_if b10 ();

   aes_iter_encrypt #(.UNROLL(1))  u_dut1  (.clk(clk), .rst(rst),    .bus(bus1));
   aes_iter_encrypt #(.UNROLL(2))  u_dut2  (.clk(clk), .rst(rst_sw), .bus(b2));
   aes_iter_encrypt #(.UNROLL(5))  u_dut5  (.clk(clk), .rst(rst_sw), .bus(b5));
   aes_iter_encrypt #(.UNROLL(10)) u_dut10 (.clk(clk), .rst(rst_sw), .bus(b10));

   // ---------------- reference model (GF(2^8) arithmetic, full key expansion)
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b};
      return t[15 - n -: 8];
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] r, b;
      r = 8'h01; b = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gmul(r, b);   // a^254 = multiplicative inverse
         b = gmul(b, b);
      end
      return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   w  [176];
      logic [7:0]   st [16];
      logic [7:0]   tm [16];
      logic [7:0]   t0, t1, t2, t3, rc;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         w[i]  = key[127 - 8*i -: 8];
         st[i] = pt[127 - 8*i -: 8] ^ w[i];
      end
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         t0 = w[i-4]; t1 = w[i-3]; t2 = w[i-2]; t3 = w[i-1];
         if (i % 16 == 0) begin
            {t0, t1, t2, t3} = {sbox_m(t1) ^ rc, sbox_m(t2), sbox_m(t3), sbox_m(t0)};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-16] ^ t0; w[i+1] = w[i-15] ^ t1;
         w[i+2] = w[i-14] ^ t2; w[i+3] = w[i-13] ^ t3;
      end
      for (int rn = 1; rn <= 10; rn++) begin
         for (int i = 0; i < 16; i++) tm[i] = sbox_m(st[i]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r + 4*c] = tm[r + 4*((c + r) % 4)];
         if (rn < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  tm[r + 4*c] = gmul(8'h02, st[r + 4*c]) ^ gmul(8'h03, st[(r+1)%4 + 4*c])
                              ^ st[(r+2)%4 + 4*c] ^ st[(r+3)%4 + 4*c];
            for (int i = 0; i < 16; i++) st[i] = tm[i];
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*rn + i];
      end
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = st[i];
      return o;
   endfunction

   // ---------------- comparison helpers
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- per-cycle compare process for the UNROLL=1 instance
   bit           m_busy, m_ov, exp_ir;
   int           m_cnt;
   logic [127:0] m_ct, m_pend;

   initial begin
      m_busy = 1'b0; m_ov = 1'b0; m_cnt = 0; m_ct = '0; m_pend = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_ir = !rst && ((!m_busy && !m_ov) || (m_ov && bus1.out_ready));
         chk_b("in_ready", bus1.in_ready, exp_ir);
         chk_b("out_valid", bus1.out_valid, m_ov);
         if (m_ov) chk("ciphertext", bus1.ciphertext, m_ct);
         if (rst) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
         end else begin
            if (m_ov && bus1.out_ready) m_ov = 1'b0;
            if (m_busy) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_busy = 1'b0;
                  m_ov   = 1'b1;
                  m_ct   = m_pend;
               end
            end else if (bus1.in_valid && exp_ir) begin
               m_busy = 1'b1;
               m_cnt  = 10;
               m_pend = aes_ref(bus1.plaintext, bus1.key);
            end
         end
      end
   end

   // ---------------- UNROLL=1 stimulus
   task automatic send(input logic [127:0] p, input logic [127:0] k, output int acc);
      bus1.plaintext = p;
      bus1.key       = k;
      bus1.in_valid  = 1'b1;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus1.in_ready) begin
            step();
            acc = cyc;
            bus1.in_valid  = 1'b0;
            bus1.plaintext = {$urandom, $urandom, $urandom, $urandom};
            bus1.key       = {$urandom, $urandom, $urandom, $urandom};
            return;
         end
      end
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready never seen, required within 200 cycles");
      bus1.in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int lat);
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus1.out_valid) begin
            lat = c;
            return;
         end
      end
      n_chk++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid never seen, required within 40 cycles");
   endtask

   always @(posedge clk) begin
      if (rand_or) begin
         #1;
         bus1.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int           a1, a2, lat;
      logic [127:0] ct0;
      rst = 1'b1;
      bus1.in_valid = 1'b0; bus1.plaintext = '0; bus1.key = '0; bus1.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ciphertext", bus1.ciphertext, '0);
      chk_b("reset_out_valid", bus1.out_valid, 1'b0);
      chk_b("reset_in_ready", bus1.in_ready, 1'b0);
      step();
      rst = 1'b0;

      chk("model_appB", aes_ref(PT_B, K_B), CT_B);
      chk("model_c1", aes_ref(PT_C, K_C), CT_C);
      chk("model_zero", aes_ref('0, '0), CT_Z);

      // FIPS-197 App. B with exact latency
      bus1.out_ready = 1'b1;
      send(PT_B, K_B, a1);
      wait_ov(lat);
      chk_i("appB_latency", lat, 10);
      chk("appB_ct", bus1.ciphertext, CT_B);
      step();

      // back-to-back streaming, in_valid held across the output-accept cycle
      send('0, '0, a1);
      bus1.plaintext = PT_B; bus1.key = K_B; bus1.in_valid = 1'b1;
      wait_ov(lat);
      chk_i("b2b_first_latency", lat, 10);
      chk("b2b_first_ct", bus1.ciphertext, CT_Z);
      chk_b("b2b_in_ready", bus1.in_ready, 1'b1);
      step();
      a2 = cyc;
      bus1.in_valid = 1'b0;
      bus1.plaintext = {$urandom, $urandom, $urandom, $urandom};
      chk_i("b2b_accept_spacing", a2 - a1, 11);
      wait_ov(lat);
      chk_i("b2b_second_latency", lat, 10);
      chk("b2b_second_ct", bus1.ciphertext, CT_B);
      step();

      // output backpressure
      bus1.out_ready = 1'b0;
      send(PT_C, K_C, a1);
      wait_ov(lat);
      chk_i("bp_latency", lat, 10);
      ct0 = bus1.ciphertext;
      chk("bp_ct", ct0, CT_C);
      for (int i = 0; i < 7; i++) begin
         chk("bp_hold_ct", bus1.ciphertext, ct0);
         chk_b("bp_hold_in_ready", bus1.in_ready, 1'b0);
         chk_b("bp_hold_out_valid", bus1.out_valid, 1'b1);
         @(negedge clk);
      end
      step();
      bus1.out_ready = 1'b1;
      @(negedge clk);
      chk_b("bp_release_in_ready", bus1.in_ready, 1'b1);
      @(negedge clk);
      chk_b("bp_release_out_valid", bus1.out_valid, 1'b0);
      step();

      // reset during round 4
      send(PT_B, K_B, a1);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk_b("rst_release_in_ready", bus1.in_ready, 1'b1);
      chk_b("rst_release_out_valid", bus1.out_valid, 1'b0);
      repeat (12) begin
         @(negedge clk);
         chk_b("rst_no_output", bus1.out_valid, 1'b0);
      end
      step();
      send(PT_C, K_C, a1);
      wait_ov(lat);
      chk_i("rst_c1_latency", lat, 10);
      chk("rst_c1_ct", bus1.ciphertext, CT_C);
      step();

      // random traffic with random sink stalls
      rand_or = 1'b1;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 3)) step();
         send({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, a1);
      end
      rand_or = 1'b0;
      step();
      step();
      bus1.out_ready = 1'b1;
      repeat (15) step();

      for (int i = 0; i < 5000 && !sweep_done; i++) step();
      if (!sweep_done) begin
         n_chk++; n_fail++;
         $display("FAIL sweep_timeout: sweep not complete, required within 5000 cycles");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // ---------------- UNROLL sweep (2, 5, 10) on shared stimulus
   initial begin
      logic [127:0] p, k, exp_ct;
      logic         ov_a [3];
      logic [127:0] ct_a [3];
      bit           seen [3];
      int           lat_e [3];
      lat_e = '{5, 2, 1};
      rst_sw = 1'b1;
      b2.in_valid = 1'b0;  b5.in_valid = 1'b0;  b10.in_valid = 1'b0;
      b2.out_ready = 1'b1; b5.out_ready = 1'b1; b10.out_ready = 1'b1;
      b2.plaintext = '0; b5.plaintext = '0; b10.plaintext = '0;
      b2.key = '0; b5.key = '0; b10.key = '0;
      repeat (3) step();
      rst_sw = 1'b0;
      for (int v = 0; v < 8; v++) begin
         if (v == 0) begin
            p = PT_C; k = K_C;
         end else begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
         end
         exp_ct = aes_ref(p, k);
         b2.plaintext = p; b5.plaintext = p; b10.plaintext = p;
         b2.key = k; b5.key = k; b10.key = k;
         @(negedge clk);
         chk_b("sweep_idle_ready", b2.in_ready && b5.in_ready && b10.in_ready, 1'b1);
         b2.in_valid = 1'b1; b5.in_valid = 1'b1; b10.in_valid = 1'b1;
         step();
         b2.in_valid = 1'b0; b5.in_valid = 1'b0; b10.in_valid = 1'b0;
         p = {$urandom, $urandom, $urandom, $urandom};
         b2.plaintext = p; b5.plaintext = p; b10.plaintext = ~p;
         b2.key = ~p; b5.key = p; b10.key = p;
         seen = '{1'b0, 1'b0, 1'b0};
         for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            ov_a = '{b2.out_valid, b5.out_valid, b10.out_valid};
            ct_a = '{b2.ciphertext, b5.ciphertext, b10.ciphertext};
            for (int j = 0; j < 3; j++) begin
               if (ov_a[j] && !seen[j]) begin
                  seen[j] = 1'b1;
                  chk_i("sweep_latency", c, lat_e[j]);
                  chk("sweep_ct", ct_a[j], exp_ct);
                  if (v == 0) chk("sweep_c1_ct", ct_a[j], CT_C);
               end
            end
         end
         for (int j = 0; j < 3; j++) chk_b("sweep_output_seen", seen[j], 1'b1);
         step();
      end
      sweep_done = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required end before 500000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
